imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
- Instruction-memory responder for the rvcpu fetch interface (inst_ena/inst_addr in, inst out).
- Accepts fetch requests, reads a word-addressed instruction SRAM array through a LATENCY-stage pipeline, and returns 32-bit instructions in order through a small response FIFO.
- Also provides a load port that the testbench or boot logic uses to preload program images.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit instruction words; power of two.
- BASE_ADDR, 64'h0000_0000_8000_0000, byte address of word 0.
- LATENCY, 2, number of cycles from request accept to FIFO push; must be ≥1.
- RESP_DEPTH, 2, maximum outstanding requests (pipeline plus FIFO); must be ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- inst_ena  input  1  fetch request valid.
- inst_addr  input  64  fetch byte address.
- inst_ready  output  1  request can be accepted this cycle.
- inst  output  32  returned instruction (FIFO head).
- inst_valid  output  1  inst/inst_err valid.
- inst_err  output  1  head response is a fault (misaligned or out of range).
- inst_resp_ready  input  1  consumer pops head when high with inst_valid.
- load_ena  input  1  preload write strobe.
- load_addr  input  $clog2(DEPTH_WORDS)  preload word index.
- load_data  input  32  preload word.

Behaviour:
- Accept: a request is accepted on a rising edge where inst_ena and inst_ready are both high. inst_ready = (inflight_cnt + fifo_cnt) < RESP_DEPTH, purely combinational from registers. It does not depend on the same-cycle pop.
- Decode at accept: err = (inst_addr[1:0] != 0) or (inst_addr < BASE_ADDR) or (inst_addr >= BASE_ADDR + 4*DEPTH_WORDS). Word index = (inst_addr - BASE_ADDR) >> 2, truncated to the index width.
- Read: the array is sampled at the accept edge. Data is mem[index], or 32'h0000_0013 (NOP) when err.
- Pipeline: data plus err travel LATENCY registered stages, each with a valid bit. They push into the FIFO at accept edge + LATENCY. For a request accepted at edge 0, inst_valid is high from cycle LATENCY when the FIFO was empty.
- FIFO: in-order, RESP_DEPTH entries, with separate read and write pointers that wrap modulo RESP_DEPTH.
  - inst/inst_err/inst_valid come from the head. When empty, inst=0, err=0, valid=0.
  - A push and a pop in the same cycle keep the count unchanged.
  - Overflow cannot occur because of the credit rule. An overflow is an assertion failure.
- Counters: inflight_cnt increments on accept and decrements on pipeline exit. A simultaneous accept and exit keeps it unchanged.
- Load port: write mem[load_addr] <= load_data on the edge when load_ena is high. When a load and an accept hit the same word on the same edge, the fetch returns the old data (read-before-write). Loads are never blocked.
- Reset (rst low, asynchronous):
  - Clears pipeline valids, FIFO pointers, inflight_cnt and fifo_cnt.
  - Outputs become inst=0, inst_valid=0, inst_err=0, inst_ready=1.
  - Memory contents are not reset.
  - Reset mid-operation discards all in-flight and queued responses. No response appears after release until new requests are accepted.
- inst_ena held with inst_ready low: no accept. The requester must hold inst_addr stable.

Optional Feature:
- Macro IMEM_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - fetch_cnt[63:0]: increments on every accept.
  - stall_cnt[63:0]: increments on every cycle with inst_ena=1 and inst_ready=0.
  - Both reset to 0 and wrap at 2^64.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Shared package imem_pkg holds:
  - INST_NOP = 32'h0000_0013.
  - Fault-cause constants IMEM_ERR_MISALIGN = 1'b0 and IMEM_ERR_RANGE = 1'b1, reserved for future cause reporting.
  - A struct/typedef for the pipeline entry {valid, err, data[31:0]}.
- One sub-module, imem_resp_fifo: a parameterised RESP_DEPTH in-order FIFO with push/pop/count/head outputs. It is instantiated once.

Test Plan:
- Basic fetch, LATENCY=2:
  - Preload mem[0]=32'h0010_0093 and mem[1]=32'h0020_0113.
  - Accept addr 0x8000_0000 at edge 0 and 0x8000_0004 at edge 1, with inst_resp_ready=1.
  - Expect inst=0x00100093 valid in cycle 2 and 0x00200113 in cycle 3, inst_err=0.
- Backpressure, RESP_DEPTH=2:
  - Hold inst_resp_ready=0 and issue 3 back-to-back requests.
  - inst_ready drops after 2 accepts.
  - The third is accepted only after one pop. Responses return in request order.
- Faults:
  - addr 0x8000_0002 → inst=0x00000013, inst_err=1.
  - addr 0x7FFF_FFFC and addr 0x8000_1000 (DEPTH 1024) → inst_err=1.
- Load/fetch collision:
  - mem[5]=0xAAAA_AAAA. Write load_data 0x5555_5555 to index 5 on the same edge as a fetch of 0x8000_0014.
  - Expect 0xAAAA_AAAA. The next fetch of the same address returns 0x5555_5555.
- Reset mid-flight:
  - Assert rst low asynchronously between edges with 2 requests outstanding.
  - inst_valid=0 immediately and inst_ready=1.
  - After release, no stale response appears for 5 cycles.
- IMEM_PERF_CNT_EN:
  - Run 4 accepts and 3 stall cycles.
  - Expect fetch_cnt=4 and stall_cnt=3; both return to 0 after reset.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // Fault causes, kept for future cause reporting on the response path.
  localparam logic IMEM_ERR_MISALIGN = 1'b0;
  localparam logic IMEM_ERR_RANGE    = 1'b1;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } pipe_entry_t;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } resp_t;

endpackage

// File: rtl/imem_responder_if.sv
// Fetch, response and preload signals of the instruction-memory responder.
interface imem_responder_if #(
  parameter int IDX_W = 10
);
  logic             inst_ena;
  logic [63:0]      inst_addr;
  logic             inst_ready;
  logic [31:0]      inst;
  logic             inst_valid;
  logic             inst_err;
  logic             inst_resp_ready;
  logic             load_ena;
  logic [IDX_W-1:0] load_addr;
  logic [31:0]      load_data;

  modport master (
    output inst_ena, inst_addr, inst_resp_ready, load_ena, load_addr, load_data,
    input  inst_ready, inst, inst_valid, inst_err
  );

  modport slave (
    input  inst_ena, inst_addr, inst_resp_ready, load_ena, load_addr, load_data,
    output inst_ready, inst, inst_valid, inst_err
  );
endinterface

// File: rtl/imem_resp_fifo.sv
// In-order response FIFO; pointers wrap modulo DEPTH so any DEPTH >= 1 works.
module imem_resp_fifo
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  resp_t         push_data,
  input  logic          pop,
  output resp_t         head,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  resp_t         slots [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          pop_ok;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty  = (count == '0);
  assign pop_ok = pop && !empty;
  assign head   = slots[rd_ptr];

  // Storage has no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) slots[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; push+pop together leaves count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok) rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop_ok)      count <= count + CW'(1);
      else if (!push && pop_ok) count <= count - CW'(1);
    end
  end

  // The credit check upstream should make this unreachable.
  overflow_chk: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop_ok && (count == CW'(DEPTH))))
    else $error("imem_resp_fifo overflow");

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: decodes fetches, reads the SRAM array,
// delays the result LATENCY cycles and returns it through an in-order FIFO.
// Optional IMEM_PERF_CNT_EN adds fetch_cnt/stall_cnt performance counters.
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned RESP_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  imem_responder_if.slave bus
`ifdef IMEM_PERF_CNT_EN
  ,
  output logic [63:0] fetch_cnt,
  output logic [63:0] stall_cnt
`endif
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam int unsigned CW       = $clog2(RESP_DEPTH + 1);
  localparam logic [63:0] END_ADDR = BASE_ADDR + (64'(DEPTH_WORDS) << 2);

  logic [31:0]      mem [DEPTH_WORDS];
  pipe_entry_t      pipe [LATENCY];
  logic [CW-1:0]    inflight_cnt;
  logic [CW-1:0]    fifo_cnt;
  logic             ready;
  logic             accept;
  logic             dec_err;
  logic [IDX_W-1:0] dec_idx;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  resp_t            fifo_head;

  // Credit only from registered counts so the requester sees a stable ready.
  assign ready   = ({1'b0, inflight_cnt} + {1'b0, fifo_cnt}) < (CW + 1)'(RESP_DEPTH);
  assign accept  = bus.inst_ena && ready;
  assign dec_err = (bus.inst_addr[1:0] != 2'b00) || (bus.inst_addr < BASE_ADDR) ||
                   (bus.inst_addr >= END_ADDR);
  assign dec_idx = IDX_W'((bus.inst_addr - BASE_ADDR) >> 2);
  assign push    = pipe[LATENCY-1].valid;
  assign pop     = bus.inst_resp_ready && !fifo_empty;

  assign bus.inst_ready = ready;
  assign bus.inst_valid = !fifo_empty;
  assign bus.inst       = fifo_empty ? 32'h0 : fifo_head.data;
  assign bus.inst_err   = fifo_empty ? 1'b0  : fifo_head.err;

  // Preload port; never blocked, and a same-edge fetch still sees old data.
  always_ff @(posedge clk) begin
    if (bus.load_ena) mem[bus.load_addr] <= bus.load_data;
  end

  // Read stage at accept, then shift through LATENCY registered stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(LATENCY); i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: accept, err: dec_err, data: dec_err ? INST_NOP : mem[dec_idx]};
      for (int i = 1; i < int'(LATENCY); i++) pipe[i] <= pipe[i-1];
    end
  end

  // Requests between accept and FIFO push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_cnt <= '0;
    end else if (accept && !push) begin
      inflight_cnt <= inflight_cnt + CW'(1);
    end else if (!accept && push) begin
      inflight_cnt <= inflight_cnt - CW'(1);
    end
  end

  imem_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ('{err: pipe[LATENCY-1].err, data: pipe[LATENCY-1].data}),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

`ifdef IMEM_PERF_CNT_EN
  // Accepted fetches and cycles a request waited on missing credit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept)                 fetch_cnt <= fetch_cnt + 64'd1;
      if (bus.inst_ena && !ready) stall_cnt <= stall_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder (LATENCY=2, RESP_DEPTH=2, DEPTH 1024).
module tb_imem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  imem_responder_if #(.IDX_W(10)) bus();

`ifdef IMEM_PERF_CNT_EN
  logic [63:0] fetch_cnt;
  logic [63:0] stall_cnt;
`endif

  imem_responder #(
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (64'h0000_0000_8000_0000),
    .LATENCY     (2),
    .RESP_DEPTH  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef IMEM_PERF_CNT_EN
    ,
    .fetch_cnt (fetch_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];      // {err, data} in request order
  logic [31:0] tb_mem [1024];

  function automatic logic [32:0] expect_of(input logic [63:0] a);
    logic       e;
    logic [9:0] idx;
    e   = (a[1:0] != 2'b00) || (a < 64'h8000_0000) || (a >= 64'h8000_1000);
    idx = a[11:2];
    return e ? {1'b1, 32'h0000_0013} : {1'b0, tb_mem[idx]};
  endfunction

  // Scoreboard: every response popped by the consumer is compared in order.
  always @(negedge clk) begin : monitor
    logic [32:0] e;
    if (rst && bus.inst_valid && bus.inst_resp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected got err=%b inst=%h expected no response",
                 bus.inst_err, bus.inst);
      end else begin
        e = exp_q.pop_front();
        if ({bus.inst_err, bus.inst} !== e) begin
          errors++;
          $display("FAIL resp_data got err=%b inst=%h expected err=%b inst=%h",
                   bus.inst_err, bus.inst, e[32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    bus.load_ena  = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    tick();
    bus.load_ena = 1'b0;
    tb_mem[a]    = d;
  endtask

  // Holds the request until accepted; pushes the expectation for the accept edge.
  task automatic fetch(input logic [63:0] a);
    int n;
    n = 0;
    bus.inst_ena  = 1'b1;
    bus.inst_addr = a;
    while (!bus.inst_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.inst_ready) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout got ready=0 expected ready=1 addr=%h", a);
      bus.inst_ena = 1'b0;
      return;
    end
    exp_q.push_back(expect_of(a));
    tick();
    bus.inst_ena = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.inst_resp_ready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) tick();
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    bus.inst_ena        = 1'b0;
    bus.inst_addr       = '0;
    bus.inst_resp_ready = 1'b0;
    bus.load_ena        = 1'b0;
    bus.load_addr       = '0;
    bus.load_data       = '0;
    repeat (2) tick();
    checks += 4;
    if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b expected 0", bus.inst_valid); end
    if (bus.inst !== 32'h0)      begin errors++; $display("FAIL rst_inst got %h expected 0", bus.inst); end
    if (bus.inst_err !== 1'b0)   begin errors++; $display("FAIL rst_err got %b expected 0", bus.inst_err); end
    if (bus.inst_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b expected 1", bus.inst_ready); end
`ifdef IMEM_PERF_CNT_EN
    checks += 2;
    if (fetch_cnt !== 64'd0) begin errors++; $display("FAIL rst_fetch_cnt got %0d expected 0", fetch_cnt); end
    if (stall_cnt !== 64'd0) begin errors++; $display("FAIL rst_stall_cnt got %0d expected 0", stall_cnt); end
`endif
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    load(10'd0,    32'h0010_0093);
    load(10'd1,    32'h0020_0113);
    load(10'd2,    32'h0030_0193);
    load(10'd3,    32'h0040_0213);
    load(10'd4,    32'h0050_0293);
    load(10'd1023, 32'h0000_8067);
    bus.inst_resp_ready = 1'b1;
    fetch(64'h8000_0000);
    fetch(64'h8000_0004);
    checks++;
    if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL basic_cycle1_valid got %b expected 0", bus.inst_valid); end
    tick();
    checks += 3;
    if (bus.inst_valid !== 1'b1)       begin errors++; $display("FAIL basic_cycle2_valid got %b expected 1", bus.inst_valid); end
    if (bus.inst !== 32'h0010_0093)    begin errors++; $display("FAIL basic_cycle2_inst got %h expected 00100093", bus.inst); end
    if (bus.inst_err !== 1'b0)         begin errors++; $display("FAIL basic_cycle2_err got %b expected 0", bus.inst_err); end
    tick();
    checks += 2;
    if (bus.inst_valid !== 1'b1)       begin errors++; $display("FAIL basic_cycle3_valid got %b expected 1", bus.inst_valid); end
    if (bus.inst !== 32'h0020_0113)    begin errors++; $display("FAIL basic_cycle3_inst got %h expected 00200113", bus.inst); end
    drain();
  endtask

  task automatic test_backpressure();
    apply_reset();
    bus.inst_resp_ready = 1'b0;
    fetch(64'h8000_0008);
    fetch(64'h8000_000C);
    checks++;
    if (bus.inst_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_after_two got %b expected 0", bus.inst_ready); end
    bus.inst_ena  = 1'b1;
    bus.inst_addr = 64'h8000_0010;
    tick();
    checks++;
    if (bus.inst_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_stall1 got %b expected 0", bus.inst_ready); end
    tick();
    checks++;
    if (bus.inst_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_stall2 got %b expected 0", bus.inst_ready); end
    bus.inst_resp_ready = 1'b1;
    tick();
    bus.inst_resp_ready = 1'b0;
    checks++;
    if (bus.inst_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop got %b expected 1", bus.inst_ready); end
    exp_q.push_back(expect_of(64'h8000_0010));
    tick();
    bus.inst_ena = 1'b0;
    drain();
    fetch(64'h8000_0000);
    drain();
`ifdef IMEM_PERF_CNT_EN
    checks += 2;
    if (fetch_cnt !== 64'd4) begin errors++; $display("FAIL perf_fetch_cnt got %0d expected 4", fetch_cnt); end
    if (stall_cnt !== 64'd3) begin errors++; $display("FAIL perf_stall_cnt got %0d expected 3", stall_cnt); end
    apply_reset();
    checks += 2;
    if (fetch_cnt !== 64'd0) begin errors++; $display("FAIL perf_fetch_cnt_rst got %0d expected 0", fetch_cnt); end
    if (stall_cnt !== 64'd0) begin errors++; $display("FAIL perf_stall_cnt_rst got %0d expected 0", stall_cnt); end
`endif
  endtask

  task automatic test_faults();
    bus.inst_resp_ready = 1'b1;
    fetch(64'h8000_0002);
    fetch(64'h7FFF_FFFC);
    fetch(64'h8000_1000);
    fetch(64'h8000_0FFC);
    fetch(64'h8000_0003);
    drain();
  endtask

  task automatic test_collision();
    load(10'd5, 32'hAAAA_AAAA);
    bus.inst_resp_ready = 1'b1;
    checks++;
    if (bus.inst_ready !== 1'b1) begin errors++; $display("FAIL coll_ready got %b expected 1", bus.inst_ready); end
    bus.load_ena  = 1'b1;
    bus.load_addr = 10'd5;
    bus.load_data = 32'h5555_5555;
    fetch(64'h8000_0014);
    bus.load_ena = 1'b0;
    tb_mem[5]    = 32'h5555_5555;
    fetch(64'h8000_0014);
    drain();
  endtask

  task automatic test_reset_midflight();
    bus.inst_resp_ready = 1'b0;
    fetch(64'h8000_0000);
    fetch(64'h8000_0004);
    tick();
    checks++;
    if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL mid_valid_before got %b expected 1", bus.inst_valid); end
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    checks += 3;
    if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_in_rst got %b expected 0", bus.inst_valid); end
    if (bus.inst_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_in_rst got %b expected 1", bus.inst_ready); end
    if (bus.inst !== 32'h0)      begin errors++; $display("FAIL mid_inst_in_rst got %h expected 0", bus.inst); end
    tick();
    rst = 1'b1;
    bus.inst_resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL mid_stale_cycle%0d got %b expected 0", i, bus.inst_valid); end
    end
    fetch(64'h8000_0004);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_faults();
    test_collision();
    test_reset_midflight();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue got %0d expected 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
